// File: rtl/r_type_issuer.sv
// Buffers MIPS instruction words and issues R-type fields to a datapath.
// Non-R-type words are dropped, and reads of the last issued rd are interlocked.
module r_type_issuer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned HAZARD_GAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic        illegal,
    output logic [7:0]  illegal_count,
    output logic [15:0] issued_count,
    output logic [3:0]  fifo_level,
    output logic [1:0]  state
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  Depth = 4'(FIFO_DEPTH);
    localparam logic [7:0]  Gap   = 8'(HAZARD_GAP);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StStall = 2'b10,
        StDrop  = 2'b11
    } state_e;

    // Shamt is never stored.
    logic [26:0]     mem_q [FIFO_DEPTH];
    logic            unused_shamt;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]      level_q, level_d;
    logic [4:0]      last_rd_q, last_rd_d;
    logic [7:0]      hz_cnt_q, hz_cnt_d;
    logic [7:0]      illegal_count_q, illegal_count_d;
    logic [15:0]     issued_count_q, issued_count_d;

    logic [26:0] head;
    logic [5:0]  head_op;
    logic        hazard;
    logic        push;
    logic        pop;
    logic        handshake;
    state_e      st;

    assign unused_shamt = ^instr[10:6];

    assign head    = mem_q[rd_ptr_q];
    assign head_op = head[26:21];
    assign rs      = head[20:16];
    assign rt      = head[15:11];
    assign rd      = head[10:6];
    assign funct   = head[5:0];

    assign instr_ready = (level_q < Depth);
    assign push        = instr_valid && instr_ready;

    // rd=0 never interlocks because last_rd_q=0 disables the compare.
    assign hazard = (hz_cnt_q != 8'd0) && (last_rd_q != 5'd0) &&
                    ((rs == last_rd_q) || (rt == last_rd_q));

    always_comb begin
        st = StIdle;
        if (level_q != 4'd0) begin
            if (head_op != 6'd0) begin
                st = StDrop;
            end else if (hazard) begin
                st = StStall;
            end else begin
                st = StIssue;
            end
        end
    end

    assign state       = st;
    assign issue_valid = (st == StIssue);
    assign illegal     = (st == StDrop);
    assign handshake   = issue_valid && issue_ready;
    assign pop         = handshake || illegal;

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        last_rd_d       = last_rd_q;
        hz_cnt_d        = hz_cnt_q;
        illegal_count_d = illegal_count_q;
        issued_count_d  = issued_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + 4'd1;
        end else if (!push && pop) begin
            level_d = level_q - 4'd1;
        end

        if (handshake) begin
            last_rd_d      = rd;
            hz_cnt_d       = Gap;
            issued_count_d = issued_count_q + 16'd1;
        end else if (hz_cnt_q != 8'd0) begin
            hz_cnt_d = hz_cnt_q - 8'd1;
        end

        if (illegal && (illegal_count_q != 8'hff)) begin
            illegal_count_d = illegal_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= 4'd0;
            last_rd_q       <= 5'd0;
            hz_cnt_q        <= 8'd0;
            illegal_count_q <= 8'd0;
            issued_count_q  <= 16'd0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            last_rd_q       <= last_rd_d;
            hz_cnt_q        <= hz_cnt_d;
            illegal_count_q <= illegal_count_d;
            issued_count_q  <= issued_count_d;
        end
    end

    // Storage needs no reset: level_q gates every use of the entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {instr[31:11], instr[5:0]};
        end
    end

    assign fifo_level    = level_q;
    assign illegal_count = illegal_count_q;
    assign issued_count  = issued_count_q;

endmodule

// File: tb/tb_r_type_issuer.sv
// Directed and random stimulus for r_type_issuer; a negedge monitor checks every cycle
// against a queue-based reference of buffered words and the interlock rule.
module tb_r_type_issuer;

    localparam int unsigned Depth = 4;
    localparam int unsigned Gap   = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic        illegal;
    logic [7:0]  illegal_count;
    logic [15:0] issued_count;
    logic [3:0]  fifo_level;
    logic [1:0]  state;

    always #5 clk = ~clk;

    r_type_issuer #(
        .FIFO_DEPTH(Depth),
        .HAZARD_GAP(Gap)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .funct         (funct),
        .illegal       (illegal),
        .illegal_count (illegal_count),
        .issued_count  (issued_count),
        .fifo_level    (fifo_level),
        .state         (state)
    );

    int tests = 0;
    int fails = 0;

    // Reference: words accepted but not yet consumed, oldest first.
    logic [31:0] q[$];
    int unsigned since_m    = 1000;
    logic [4:0]  last_rd_m  = 5'd0;
    logic [15:0] exp_issued = 16'd0;
    logic [7:0]  exp_ill    = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        since_m    = 1000;
        last_rd_m  = 5'd0;
        exp_issued = 16'd0;
        exp_ill    = 8'd0;
    endtask

    task automatic cyc(input logic v, input logic [31:0] w, input logic r);
        @(posedge clk);
        #1;
        instr_valid = v;
        instr       = w;
        issue_ready = r;
    endtask

    function automatic logic [31:0] rtype(input int s, input int t, input int d, input int f);
        return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(f)};
    endfunction

    always @(posedge clk) begin
        if (!rst && instr_valid && instr_ready) q.push_back(instr);
    end

    logic [31:0] h;
    logic [1:0]  exp_st;
    logic        hz;

    always @(negedge clk) begin
        if (!rst) begin
            if (since_m < 1000) since_m++;
            chk("issued_count", 32'(issued_count), 32'(exp_issued));
            chk("illegal_count", 32'(illegal_count), 32'(exp_ill));
            chk("fifo_level", 32'(fifo_level), q.size());
            chk("instr_ready", 32'(instr_ready), 32'(q.size() < Depth));
            exp_st = 2'd0;
            h      = 32'd0;
            if (q.size() != 0) begin
                h  = q[0];
                hz = (since_m <= Gap) && (last_rd_m != 5'd0) &&
                     ((h[25:21] == last_rd_m) || (h[20:16] == last_rd_m));
                if (h[31:26] != 6'd0) exp_st = 2'd3;
                else if (hz)          exp_st = 2'd2;
                else                  exp_st = 2'd1;
            end
            chk("state", 32'(state), 32'(exp_st));
            chk("issue_valid", 32'(issue_valid), 32'(exp_st == 2'd1));
            chk("illegal", 32'(illegal), 32'(exp_st == 2'd3));
            if (exp_st == 2'd1) begin
                chk("fields", 32'({rs, rt, rd, funct}), 32'({h[25:11], h[5:0]}));
                if (issue_ready) begin
                    void'(q.pop_front());
                    exp_issued++;
                    last_rd_m = h[15:11];
                    since_m   = 0;
                end
            end else if (exp_st == 2'd3) begin
                void'(q.pop_front());
                if (exp_ill != 8'hff) exp_ill++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    logic [31:0] w;
    int          n;
    int          guard;

    initial begin
        instr       = 32'd0;
        instr_valid = 1'b0;
        issue_ready = 1'b0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ready", 32'(instr_ready), 1);
        chk("rst_valid", 32'(issue_valid), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_issued", 32'(issued_count), 0);
        chk("rst_illcnt", 32'(illegal_count), 0);
        rst = 1'b0;

        // Single add: one-cycle latency.
        cyc(1'b1, 32'h00221820, 1'b1);
        cyc(1'b0, 32'd0, 1'b1);
        chk("add_state", 32'(state), 1);
        chk("add_valid", 32'(issue_valid), 1);
        chk("add_rs", 32'(rs), 1);
        chk("add_rt", 32'(rt), 2);
        chk("add_rd", 32'(rd), 3);
        chk("add_funct", 32'(funct), 32'h20);
        cyc(1'b0, 32'd0, 1'b1);
        chk("add_count", 32'(issued_count), 1);
        chk("add_idle", 32'(state), 0);

        // Back-to-back dependent pair stalls one cycle.
        cyc(1'b1, 32'h00221820, 1'b1);
        cyc(1'b1, 32'h00612022, 1'b1);
        chk("dep_first", 32'(state), 1);
        cyc(1'b0, 32'd0, 1'b1);
        chk("dep_stall", 32'(state), 2);
        chk("dep_nvalid", 32'(issue_valid), 0);
        cyc(1'b0, 32'd0, 1'b1);
        chk("dep_issue", 32'(state), 1);
        chk("dep_fields", 32'({rs, rt, rd, funct}), 32'({5'd3, 5'd1, 5'd4, 6'h22}));
        repeat (2) cyc(1'b0, 32'd0, 1'b1);

        // Non-R-type drop and counter saturation.
        cyc(1'b1, 32'h8C220004, 1'b1);
        cyc(1'b0, 32'd0, 1'b1);
        chk("drop_state", 32'(state), 3);
        chk("drop_pulse", 32'(illegal), 1);
        chk("drop_nvalid", 32'(issue_valid), 0);
        cyc(1'b0, 32'd0, 1'b1);
        chk("drop_end", 32'(illegal), 0);
        chk("drop_count", 32'(illegal_count), 1);
        repeat (300) cyc(1'b1, 32'h8C220004, 1'b1);
        repeat (3) cyc(1'b0, 32'd0, 1'b1);
        chk("drop_sat", 32'(illegal_count), 255);

        // Backpressure fills the buffer; order preserved on release.
        n     = 0;
        guard = 0;
        while (n < 4 && guard < 20) begin
            cyc(1'b1, rtype(0, 0, 8 + n, 32'h20), 1'b0);
            if (instr_ready) n++;
            guard++;
        end
        chk("fill_pushes", 32'(n), 4);
        cyc(1'b1, rtype(0, 0, 12, 32'h20), 1'b0);
        chk("full_ready", 32'(instr_ready), 0);
        chk("full_level", 32'(fifo_level), 4);
        chk("full_head", 32'(rd), 8);
        cyc(1'b1, rtype(0, 0, 12, 32'h20), 1'b0);
        chk("hold_head", 32'(rd), 8);
        chk("hold_valid", 32'(issue_valid), 1);
        cyc(1'b1, rtype(0, 0, 12, 32'h20), 1'b1);
        chk("full_pop_ready", 32'(instr_ready), 0);
        cyc(1'b1, rtype(0, 0, 12, 32'h20), 1'b1);
        chk("after_pop_ready", 32'(instr_ready), 1);
        repeat (6) cyc(1'b0, 32'd0, 1'b1);
        chk("drain_count", 32'(issued_count), 8);
        chk("drain_level", 32'(fifo_level), 0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) cyc(1'b1, rtype(1, 2, 5 + i, 32'h20), 1'b0);
        cyc(1'b0, 32'd0, 1'b0);
        chk("pre_rst_level", 32'(fifo_level), 3);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_level", 32'(fifo_level), 0);
        chk("arst_valid", 32'(issue_valid), 0);
        chk("arst_issued", 32'(issued_count), 0);
        chk("arst_illcnt", 32'(illegal_count), 0);
        chk("arst_state", 32'(state), 0);
        chk("arst_ready", 32'(instr_ready), 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (4) cyc(1'b0, 32'd0, 1'b1);
        chk("post_rst_valid", 32'(issue_valid), 0);
        chk("post_rst_issued", 32'(issued_count), 0);

        // Random traffic with small register ranges to provoke hazards and rd=0.
        repeat (600) begin
            w         = $urandom;
            w[25:21]  = 5'($urandom_range(0, 3));
            w[20:16]  = 5'($urandom_range(0, 3));
            w[15:11]  = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 4) != 0) w[31:26] = 6'd0;
            else if (w[31:26] == 6'd0)     w[31:26] = 6'd35;
            cyc(1'($urandom_range(0, 99) < 60), w, 1'($urandom_range(0, 99) < 70));
        end
        guard = 0;
        cyc(1'b0, 32'd0, 1'b1);
        while (fifo_level != 4'd0 && guard < 50) begin
            cyc(1'b0, 32'd0, 1'b1);
            guard++;
        end
        chk("final_level", 32'(fifo_level), 0);
        cyc(1'b0, 32'd0, 1'b1);
        chk("final_queue", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
